// File: rtl/calc1_port_driver_if.sv
// Operation and result handshake channels between a client and one calc1 port driver.
interface calc1_port_driver_if;
    // Operation channel (client -> driver)
    logic        op_valid;
    logic        op_ready;
    logic [3:0]  op_cmd;
    logic [31:0] op_data1;
    logic [31:0] op_data2;

    // Result channel (driver -> client)
    logic        res_valid;
    logic        res_ready;
    logic [1:0]  res_resp;
    logic [31:0] res_data;

    // Client side: offers operations and consumes results
    modport master (
        output op_valid, op_cmd, op_data1, op_data2, res_ready,
        input  op_ready, res_valid, res_resp, res_data
    );

    // Driver side
    modport slave (
        input  op_valid, op_cmd, op_data1, op_data2, res_ready,
        output op_ready, res_valid, res_resp, res_data
    );
endinterface

// File: rtl/calc1_port_driver.sv
// Upstream driver for one calc1 request port: accepts a full operation, serialises it into
// calc1's two-cycle request format, waits (with timeout) for the response and hands it back.
module calc1_port_driver #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = 16
) (
    input  logic                 c_clk,
    input  logic                 reset_n,
    calc1_port_driver_if.slave   port,
    output logic [3:0]           req_cmd_out,
    output logic [31:0]          req_data_out,
    input  logic [1:0]           out_resp,
    input  logic [31:0]          out_data,
    output logic                 busy,
    output logic                 stray_resp,
    output logic [CNT_W-1:0]     done_count
);

    localparam logic [15:0] TimerLast = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSend1,
        StSend2,
        StWait,
        StHold
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       data2_q, data2_d;
    logic [3:0]        req_cmd_q, req_cmd_d;
    logic [31:0]       req_data_q, req_data_d;
    logic              res_valid_q, res_valid_d;
    logic [1:0]        res_resp_q, res_resp_d;
    logic [31:0]       res_data_q, res_data_d;
    logic [15:0]       timer_q, timer_d;
    logic              stray_q, stray_d;
    logic [CNT_W-1:0]  count_q, count_d;

    // State and registered outputs
    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            data2_q     <= '0;
            req_cmd_q   <= '0;
            req_data_q  <= '0;
            res_valid_q <= 1'b0;
            res_resp_q  <= '0;
            res_data_q  <= '0;
            timer_q     <= '0;
            stray_q     <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            data2_q     <= data2_d;
            req_cmd_q   <= req_cmd_d;
            req_data_q  <= req_data_d;
            res_valid_q <= res_valid_d;
            res_resp_q  <= res_resp_d;
            res_data_q  <= res_data_d;
            timer_q     <= timer_d;
            stray_q     <= stray_d;
            count_q     <= count_d;
        end
    end

    // Next-state: request serialisation, response capture, timeout and handoff
    always_comb begin
        state_d     = state_q;
        data2_d     = data2_q;
        req_cmd_d   = req_cmd_q;
        req_data_d  = req_data_q;
        res_valid_d = res_valid_q;
        res_resp_d  = res_resp_q;
        res_data_d  = res_data_q;
        timer_d     = timer_q;
        count_d     = count_q;
        // Any response outside WAIT is unsolicited; it only raises the sticky flag.
        stray_d     = stray_q | ((out_resp != 2'd0) && (state_q != StWait));

        unique case (state_q)
            StIdle: begin
                if (port.op_valid) begin
                    if (port.op_cmd == 4'd0) begin
                        // Null command never reaches calc1; report it as invalid.
                        res_valid_d = 1'b1;
                        res_resp_d  = 2'd2;
                        res_data_d  = '0;
                        state_d     = StHold;
                    end else begin
                        req_cmd_d  = port.op_cmd;
                        req_data_d = port.op_data1;
                        data2_d    = port.op_data2;
                        state_d    = StSend1;
                    end
                end
            end
            StSend1: begin
                req_cmd_d  = '0;
                req_data_d = data2_q;
                state_d    = StSend2;
            end
            StSend2: begin
                req_cmd_d  = '0;
                req_data_d = '0;
                timer_d    = '0;
                state_d    = StWait;
            end
            StWait: begin
                timer_d = timer_q + 16'd1;
                // Response takes priority over a timeout in the same cycle.
                if (out_resp != 2'd0) begin
                    res_valid_d = 1'b1;
                    res_resp_d  = out_resp;
                    res_data_d  = out_data;
                    state_d     = StHold;
                end else if (timer_q == TimerLast) begin
                    res_valid_d = 1'b1;
                    res_resp_d  = 2'd3;
                    res_data_d  = '0;
                    state_d     = StHold;
                end
            end
            StHold: begin
                if (res_valid_q && port.res_ready) begin
                    res_valid_d = 1'b0;
                    count_d     = count_q + 1'b1;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign port.op_ready  = (state_q == StIdle);
    assign busy           = (state_q != StIdle);
    assign port.res_valid = res_valid_q;
    assign port.res_resp  = res_resp_q;
    assign port.res_data  = res_data_q;
    assign req_cmd_out    = req_cmd_q;
    assign req_data_out   = req_data_q;
    assign stray_resp     = stray_q;
    assign done_count     = count_q;

endmodule

// File: tb/tb_calc1_port_driver.sv
// Self-checking bench for calc1_port_driver with an inline calc1 responder and reference model.
module tb_calc1_port_driver;

    localparam int unsigned TO = 8;
    localparam int unsigned CW = 4;

    logic          c_clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [3:0]    req_cmd_out;
    logic [31:0]   req_data_out;
    logic [1:0]    out_resp;
    logic [31:0]   out_data;
    logic          busy;
    logic          stray_resp;
    logic [CW-1:0] done_count;

    int checks = 0;
    int failures = 0;
    int exp_count = 0;

    calc1_port_driver_if bus ();

    calc1_port_driver #(
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (CW)
    ) dut (
        .c_clk        (c_clk),
        .reset_n      (reset_n),
        .port         (bus),
        .req_cmd_out  (req_cmd_out),
        .req_data_out (req_data_out),
        .out_resp     (out_resp),
        .out_data     (out_data),
        .busy         (busy),
        .stray_resp   (stray_resp),
        .done_count   (done_count)
    );

    always #5 c_clk = ~c_clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge c_clk);
        #1;
    endtask

    // calc1 behaviour: add/sub with carry/borrow detection, logical shifts, else invalid.
    function automatic void model(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                                  output logic [1:0] r, output logic [31:0] d);
        logic [32:0] s;
        r = 2'd2;
        d = '0;
        case (cmd)
            4'd1: begin
                s = {1'b0, a} + {1'b0, b};
                if (!s[32]) begin r = 2'd1; d = s[31:0]; end
            end
            4'd2: if (b <= a) begin r = 2'd1; d = a - b; end
            4'd5: begin r = 2'd1; d = a << b[4:0]; end
            4'd6: begin r = 2'd1; d = a >> b[4:0]; end
            default: ;
        endcase
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!bus.op_ready && n < 50) begin step(); n++; end
        chk("op_ready_wait", 32'(bus.op_ready), 32'd1);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_req_cmd"}, 32'(req_cmd_out), 32'd0);
        chk({tag, "_req_data"}, req_data_out, 32'd0);
        chk({tag, "_res_valid"}, 32'(bus.res_valid), 32'd0);
        chk({tag, "_res_resp"}, 32'(bus.res_resp), 32'd0);
        chk({tag, "_res_data"}, bus.res_data, 32'd0);
        chk({tag, "_stray"}, 32'(stray_resp), 32'd0);
        chk({tag, "_done"}, 32'(done_count), 32'd0);
        chk({tag, "_op_ready"}, 32'(bus.op_ready), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    // lat < 0: responder stays silent so the driver must time out.
    task automatic run_op(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input int hold, input bit stray_in_hold);
        logic [1:0]  er, rr;
        logic [31:0] ed, rd, s1, s2;
        logic [3:0]  sc;
        int          n;
        model(cmd, a, b, er, ed);
        wait_ready();
        bus.op_valid = 1'b1;
        bus.op_cmd   = cmd;
        bus.op_data1 = a;
        bus.op_data2 = b;
        step();
        bus.op_valid = 1'b0;
        bus.op_cmd   = 4'($urandom);
        bus.op_data1 = $urandom;
        bus.op_data2 = $urandom;
        if (cmd == 4'd0) begin
            chk("null_req_cmd", 32'(req_cmd_out), 32'd0);
        end else begin
            chk("send1_cmd", 32'(req_cmd_out), 32'(cmd));
            chk("send1_data", req_data_out, a);
            sc = req_cmd_out;
            s1 = req_data_out;
            step();
            chk("send2_cmd", 32'(req_cmd_out), 32'd0);
            chk("send2_data", req_data_out, b);
            s2 = req_data_out;
            step();
            chk("wait_req_cmd", 32'(req_cmd_out), 32'd0);
            chk("wait_busy", 32'(busy), 32'd1);
            if (lat < 0) begin
                n = 0;
                while (!bus.res_valid && n < 40) begin step(); n++; end
                chk("timeout_cycles", 32'(n), 32'(TO));
                er = 2'd3;
                ed = '0;
            end else begin
                repeat (lat) step();
                model(sc, s1, s2, rr, rd);
                out_resp = rr;
                out_data = rd;
                step();
                out_resp = 2'd0;
                out_data = $urandom;
            end
        end
        chk("res_valid", 32'(bus.res_valid), 32'd1);
        chk("res_resp", 32'(bus.res_resp), 32'(er));
        chk("res_data", bus.res_data, ed);
        for (int i = 0; i < hold; i++) begin
            if (stray_in_hold && i == 0) begin
                out_resp = 2'd1;
                out_data = 32'hDEAD_BEEF;
            end
            step();
            out_resp = 2'd0;
            chk("hold_valid", 32'(bus.res_valid), 32'd1);
            chk("hold_resp", 32'(bus.res_resp), 32'(er));
            chk("hold_data", bus.res_data, ed);
            chk("hold_op_ready", 32'(bus.op_ready), 32'd0);
        end
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        exp_count++;
        chk("handoff_valid", 32'(bus.res_valid), 32'd0);
        chk("handoff_count", 32'(done_count), 32'(exp_count % (1 << CW)));
        chk("handoff_op_ready", 32'(bus.op_ready), 32'd1);
    endtask

    initial begin
        logic [3:0] cmds [5];
        cmds = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd3};
        bus.op_valid  = 1'b0;
        bus.op_cmd    = '0;
        bus.op_data1  = '0;
        bus.op_data2  = '0;
        bus.res_ready = 1'b0;
        out_resp      = '0;
        out_data      = '0;

        repeat (4) step();
        check_reset_state("in_reset");
        reset_n = 1'b1;
        step();
        check_reset_state("after_reset");

        // Directed arithmetic cases
        run_op(4'd1, 32'h0000_0001, 32'h01FF_FFFF, 2, 0, 1'b0);
        chk("first_done_count", 32'(done_count), 32'd1);
        run_op(4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 1, 0, 1'b0);
        run_op(4'd2, 32'h0000_0001, 32'h0000_000F, 0, 0, 1'b0);
        run_op(4'd3, 32'h0000_0005, 32'h0000_0006, 3, 0, 1'b0);
        run_op(4'd0, 32'h0000_0007, 32'h0000_0008, 0, 0, 1'b0);

        // Long hold with a second response injected while holding
        chk("stray_before_hold", 32'(stray_resp), 32'd0);
        run_op(4'd6, 32'h8000_0000, 32'h0000_0004, 1, 10, 1'b1);
        chk("stray_from_hold", 32'(stray_resp), 32'd1);

        // Silent responder
        run_op(4'd5, 32'h0000_0003, 32'h0000_0002, -1, 2, 1'b0);

        // Randomised operations
        for (int i = 0; i < 8; i++) begin
            run_op(cmds[$urandom_range(0, 4)], $urandom, $urandom,
                   int'($urandom_range(0, 5)), int'($urandom_range(0, 3)), 1'b0);
        end

        // Reset asserted in WAIT
        wait_ready();
        bus.op_valid = 1'b1;
        bus.op_cmd   = 4'd1;
        bus.op_data1 = 32'h1234_5678;
        bus.op_data2 = 32'h0000_0010;
        step();
        bus.op_valid = 1'b0;
        step();
        step();
        chk("pre_reset_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        exp_count = 0;
        check_reset_state("wait_reset");
        step();
        step();
        reset_n = 1'b1;
        step();
        check_reset_state("wait_reset_release");

        // Unsolicited response while idle
        out_resp = 2'd1;
        out_data = 32'hCAFE_F00D;
        step();
        out_resp = 2'd0;
        chk("stray_idle", 32'(stray_resp), 32'd1);
        chk("stray_idle_valid", 32'(bus.res_valid), 32'd0);
        chk("stray_idle_data", bus.res_data, 32'd0);
        repeat (3) step();
        chk("stray_sticky", 32'(stray_resp), 32'd1);

        // Counter wrap over 2^CW + 2 shift operations
        for (int n = 0; n < (1 << CW) + 2; n++) begin
            run_op(4'd5, 32'd1, 32'(n % 32), int'($urandom_range(0, 5)), 0, 1'b0);
        end
        chk("done_count_wrap", 32'(done_count), 32'd2);
        chk("stray_end", 32'(stray_resp), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/calc1_port_driver.md
Name: calc1_port_driver

Overview:
- Upstream stage for one calc1 request port. Accepts a complete operation (command plus two operands) on a valid/ready interface.
- Serialises the operation into calc1's two-cycle request protocol, then waits for calc1's one-cycle response.
- Returns the response and result on a result valid/ready interface. Four instances (ports 1-4) feed calc1.
- Adds a response timeout, stray-response detection and a completed-operation counter.

Parameters:
- TIMEOUT_CYCLES, 64: maximum cycles spent in WAIT before the operation is declared timed out; legal range 2..65535.
- CNT_W, 16: width of done_count.

Ports:
- c_clk  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- op_valid  in  1  operation offered.
- op_ready  out  1  driver can accept an operation.
- op_cmd  in  4  calc1 command: 1 add, 2 sub, 5 shift left, 6 shift right; other values are still sent to calc1.
- op_data1  in  32  first operand.
- op_data2  in  32  second operand, or shift amount.
- req_cmd_out  out  4  to calc1 reqN_cmd_in.
- req_data_out  out  32  to calc1 reqN_data_in.
- out_resp  in  2  from calc1 out_respN: 0 none, 1 success, 2 overflow/underflow/invalid, 3 unused.
- out_data  in  32  from calc1 out_dataN.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_resp  out  2  captured response; 3 = timeout.
- res_data  out  32  captured result data.
- busy  out  1  high in every state except IDLE.
- stray_resp  out  1  sticky error flag.
- done_count  out  CNT_W  results handed off; wraps modulo 2^CNT_W.

Behaviour:
- Reset (async assert, sync deassert by design):
  - state = IDLE; req_cmd_out = 0, req_data_out = 0.
  - res_valid = 0, res_resp = 0, res_data = 0.
  - stray_resp = 0, done_count = 0, timer = 0.
  - Reset mid-operation abandons the operation silently; calc1 reset is handled externally.
- All outputs are registered except op_ready and busy, which decode the state.
- States: IDLE, SEND1, SEND2, WAIT, HOLD.
- IDLE:
  - op_ready = 1. On op_valid & op_ready at edge k: capture cmd, data1, data2.
  - At the same edge k, req_cmd_out = op_cmd and req_data_out = op_data1; go to SEND1.
  - op_cmd = 0: nothing is driven to calc1. Go directly to HOLD with res_resp = 2, res_data = 0.
- SEND1: edge k+1 loads req_cmd_out = 0 and req_data_out = data2; go to SEND2.
  - Net effect: calc1 sees cmd/data1 during cycle k+1 and cmd 0/data2 during cycle k+2, matching its two-cycle request format.
- SEND2: edge k+2 loads req_cmd_out = 0, req_data_out = 0 and clears the timer; go to WAIT.
- WAIT:
  - Timer increments every cycle.
  - On the first cycle with out_resp != 0: capture out_resp and out_data into res_resp/res_data, set res_valid, go to HOLD. Response is sampled exactly once.
  - If timer reaches TIMEOUT_CYCLES-1 with no response: res_resp = 3, res_data = 0, res_valid = 1, go to HOLD.
  - If a response and the timeout occur in the same cycle, the response wins.
- HOLD:
  - res_valid held with stable res_resp/res_data until res_ready.
  - On res_valid & res_ready: clear res_valid, increment done_count, go to IDLE.
  - op_ready stays 0 in HOLD, so there is no same-cycle re-accept; back-to-back operations are spaced by at least one IDLE cycle.
- stray_resp:
  - Set when out_resp != 0 in any state other than WAIT (including a second response while in HOLD).
  - Cleared only by reset. A stray response never alters res_* fields.
- done_count wraps from 2^CNT_W-1 to 0.
- op_data/op_cmd are ignored outside the accept cycle; changing them afterwards has no effect.

Test Plan:
- Reset held 4 cycles then released -> all outputs 0, op_ready = 1, busy = 0. Assert reset_n low during WAIT -> immediate return to reset values.
- Add op_cmd = 1, data1 = 0x0000_0001, data2 = 0x01FF_FFFF with calc1 -> req_cmd_out shows 1 then 0 on consecutive cycles; result res_resp = 1, res_data = 0x0200_0000; done_count = 1.
- Add data1 = 0xFFFF_FFFF, data2 = 0x0000_0001 -> res_resp = 2. Sub data1 = 1, data2 = 0xF -> res_resp = 2. Invalid op_cmd = 3 -> res_resp = 2.
- Responder model that never answers, TIMEOUT_CYCLES = 8 -> res_valid rises exactly 8 cycles after entering WAIT with res_resp = 3, res_data = 0.
- Hold res_ready low 10 cycles after a result -> res_* stable and op_ready = 0 throughout. Inject out_resp = 1 while in IDLE -> stray_resp = 1 and stays set.
- 2^CNT_W + 2 back-to-back shift ops (cmd 5, data1 = 1, data2 = n mod 32) -> each res_data = 1 << n; done_count wraps to 2.
